// File: rtl/axis_fir_sink_pkg.sv
// Shared types and constants for the FIR output-stream sink and its throttle.
// Default widths match the FIR datapath this sink terminates.
package axis_fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    ACCUM = 2'd2
  } fir_state_e;

  localparam int FIR_OUT_W = 32;
  localparam int FIR_IN_W  = 16;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_SUM_W = 48;

  // Saturation ceiling for counters at the default counter width.
  localparam logic [DEF_CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/axis_fir_sink_if.sv
// AXI-Stream beat bundle (tdata/tkeep/tvalid/tlast/tready) with master and
// slave views.
interface axis_fir_sink_if
  import axis_fir_pkg::*;
#(
  parameter int DATA_W = FIR_OUT_W
) ();

  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tvalid;
  logic                tlast;
  logic                tready;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);

endinterface

// File: rtl/axis_fir_sink_throttle.sv
// Periodic back-pressure generator: a free-running period counter that flags
// the first THR_LOW cycles of every THR_PERIOD enabled cycles.
module axis_throttle #(
  parameter int unsigned THR_PERIOD = 0,
  parameter int unsigned THR_LOW    = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic enable_i,
  output logic throttleLow_o
);

  localparam int unsigned CW = (THR_PERIOD > 1) ? $clog2(THR_PERIOD) : 1;
  localparam logic [CW-1:0] LAST_C = (THR_PERIOD > 0) ? CW'(THR_PERIOD - 1) : '0;

  logic [CW-1:0] thrCnt_q;
  logic [CW-1:0] thrCnt_d;

  always_comb begin
    thrCnt_d = thrCnt_q;
    if (enable_i) begin
      thrCnt_d = (thrCnt_q == LAST_C) ? '0 : thrCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      thrCnt_q <= '0;
    end else begin
      thrCnt_q <= thrCnt_d;
    end
  end

  // A zero period or zero low-count never throttles, so no compare is built.
  if (THR_PERIOD == 0 || THR_LOW == 0) begin : g_noThrottle
    assign throttleLow_o = 1'b0;
  end else begin : g_throttle
    localparam logic [CW-1:0] LOW_C = CW'(THR_LOW);
    assign throttleLow_o = (thrCnt_q < LOW_C);
  end

endmodule

// File: rtl/axis_fir_sink.sv
// AXI-Stream sink for the FIR output: accepts signed samples under optional
// periodic back-pressure and latches per-frame count/min/max/sum/zero-crossings.
module axis_fir_sink
  import axis_fir_pkg::*;
#(
  parameter int          DATA_W     = FIR_OUT_W,
  parameter int          CNT_W      = DEF_CNT_W,
  parameter int          SUM_W      = DEF_SUM_W,
  parameter int unsigned THR_PERIOD = 0,
  parameter int unsigned THR_LOW    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  axis_fir_sink_if.slave    s_axis,
  output logic              frame_done,
  output logic [CNT_W-1:0]  stat_count,
  output logic [DATA_W-1:0] stat_min,
  output logic [DATA_W-1:0] stat_max,
  output logic [SUM_W-1:0]  stat_sum,
  output logic [CNT_W-1:0]  stat_zc,
  output logic              stat_ovf,
  output logic              keep_err
);

  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  fir_state_e state_q, state_d;
  fir_state_e resume_q, resume_d;

  logic [CNT_W-1:0]         cnt_q, cntNext;
  logic [CNT_W-1:0]         zc_q, zcNext;
  logic signed [DATA_W-1:0] min_q, minNext;
  logic signed [DATA_W-1:0] max_q, maxNext;
  logic signed [SUM_W-1:0]  sum_q, sumNext;
  logic                     ovf_q, ovfNext;
  logic                     prevSign_q;

  logic [CNT_W-1:0]  statCount_q, statZc_q;
  logic [DATA_W-1:0] statMin_q, statMax_q;
  logic [SUM_W-1:0]  statSum_q;
  logic              statOvf_q, done_q, keepErr_q;

  logic                     throttleLow;
  logic                     ready;
  logic                     accept;
  logic                     frameEnd;
  logic signed [DATA_W-1:0] sample;
  logic                     sampleSign;

  axis_throttle #(
    .THR_PERIOD (THR_PERIOD),
    .THR_LOW    (THR_LOW)
  ) u_throttle (
    .clk           (clk),
    .reset         (reset),
    .enable_i      (enable),
    .throttleLow_o (throttleLow)
  );

  assign ready         = enable && (state_q != IDLE) && !throttleLow;
  assign s_axis.tready = ready;
  assign accept        = s_axis.tvalid && ready;
  assign frameEnd      = accept && s_axis.tlast && !clear;
  assign sample        = s_axis.tdata;
  assign sampleSign    = s_axis.tdata[DATA_W-1];

  // Accumulator values as they would stand after the beat on the bus; the
  // first beat of a frame seeds them instead of folding into stale state.
  always_comb begin
    cntNext = cnt_q;
    zcNext  = zc_q;
    minNext = min_q;
    maxNext = max_q;
    sumNext = sum_q;
    ovfNext = ovf_q;
    if (state_q == FIRST) begin
      cntNext = {{(CNT_W-1){1'b0}}, 1'b1};
      zcNext  = '0;
      minNext = sample;
      maxNext = sample;
      sumNext = SUM_W'(sample);
      ovfNext = 1'b0;
    end else begin
      cntNext = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
      ovfNext = ovf_q | (cnt_q == CNT_SAT);
      minNext = (sample < min_q) ? sample : min_q;
      maxNext = (sample > max_q) ? sample : max_q;
      sumNext = sum_q + SUM_W'(sample);
      zcNext  = ((sampleSign != prevSign_q) && (zc_q != CNT_SAT)) ? zc_q + 1'b1 : zc_q;
    end
  end

  // Disabling parks in IDLE but remembers whether a frame was in progress.
  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = resume_q;
      end
      FIRST, ACCUM: begin
        if (!enable) begin
          state_d  = IDLE;
          resume_d = state_q;
        end else if (accept) begin
          state_d = s_axis.tlast ? FIRST : ACCUM;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      resume_d = FIRST;
      state_d  = enable ? FIRST : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      resume_q   <= FIRST;
      cnt_q      <= '0;
      zc_q       <= '0;
      min_q      <= '0;
      max_q      <= '0;
      sum_q      <= '0;
      ovf_q      <= 1'b0;
      prevSign_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      if (clear) begin
        cnt_q      <= '0;
        zc_q       <= '0;
        min_q      <= '0;
        max_q      <= '0;
        sum_q      <= '0;
        ovf_q      <= 1'b0;
        prevSign_q <= 1'b0;
      end else if (accept) begin
        cnt_q      <= cntNext;
        zc_q       <= zcNext;
        min_q      <= minNext;
        max_q      <= maxNext;
        sum_q      <= sumNext;
        ovf_q      <= ovfNext;
        prevSign_q <= sampleSign;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      statCount_q <= '0;
      statZc_q    <= '0;
      statMin_q   <= '0;
      statMax_q   <= '0;
      statSum_q   <= '0;
      statOvf_q   <= 1'b0;
      done_q      <= 1'b0;
      keepErr_q   <= 1'b0;
    end else begin
      done_q <= frameEnd;
      if (frameEnd) begin
        statCount_q <= cntNext;
        statZc_q    <= zcNext;
        statMin_q   <= minNext;
        statMax_q   <= maxNext;
        statSum_q   <= sumNext;
        statOvf_q   <= ovfNext;
      end
      if (accept && (s_axis.tkeep != '1)) keepErr_q <= 1'b1;
    end
  end

  assign frame_done = done_q;
  assign stat_count = statCount_q;
  assign stat_min   = statMin_q;
  assign stat_max   = statMax_q;
  assign stat_sum   = statSum_q;
  assign stat_zc    = statZc_q;
  assign stat_ovf   = statOvf_q;
  assign keep_err   = keepErr_q;

endmodule

// File: tb/tb_axis_fir_sink.sv
// Bench for axis_fir_sink: an unthrottled instance (A) and a throttled,
// narrow-counter instance (B), both checked every cycle against a frame model.
module tb_axis_fir_sink;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2], en[2], clr[2], tvalid[2], tlast[2];
  logic [31:0] tdata[2];
  logic [3:0]  tkeep[2];

  axis_fir_sink_if #(.DATA_W(32)) ifA ();
  axis_fir_sink_if #(.DATA_W(32)) ifB ();

  assign ifA.tdata  = tdata[0];
  assign ifA.tkeep  = tkeep[0];
  assign ifA.tvalid = tvalid[0];
  assign ifA.tlast  = tlast[0];
  assign ifB.tdata  = tdata[1];
  assign ifB.tkeep  = tkeep[1];
  assign ifB.tvalid = tvalid[1];
  assign ifB.tlast  = tlast[1];

  logic        doneA, ovfA, keA, doneB, ovfB, keB;
  logic [15:0] countA, zcA;
  logic [3:0]  countB, zcB;
  logic [31:0] minA, maxA, minB, maxB;
  logic [47:0] sumA, sumB;

  axis_fir_sink #(.DATA_W(32), .CNT_W(16), .SUM_W(48), .THR_PERIOD(0), .THR_LOW(0)) dutA (
    .clk(clk), .reset(rst[0]), .enable(en[0]), .clear(clr[0]), .s_axis(ifA),
    .frame_done(doneA), .stat_count(countA), .stat_min(minA), .stat_max(maxA),
    .stat_sum(sumA), .stat_zc(zcA), .stat_ovf(ovfA), .keep_err(keA));

  axis_fir_sink #(.DATA_W(32), .CNT_W(4), .SUM_W(48), .THR_PERIOD(10), .THR_LOW(3)) dutB (
    .clk(clk), .reset(rst[1]), .enable(en[1]), .clear(clr[1]), .s_axis(ifB),
    .frame_done(doneB), .stat_count(countB), .stat_min(minB), .stat_max(maxB),
    .stat_sum(sumB), .stat_zc(zcB), .stat_ovf(ovfB), .keep_err(keB));

  logic        actReady[2], actDone[2], actOvf[2], actKe[2];
  logic [63:0] actCount[2], actMin[2], actMax[2], actSum[2], actZc[2];

  assign actReady[0] = ifA.tready;
  assign actDone[0]  = doneA;
  assign actOvf[0]   = ovfA;
  assign actKe[0]    = keA;
  assign actCount[0] = 64'(countA);
  assign actMin[0]   = 64'(minA);
  assign actMax[0]   = 64'(maxA);
  assign actSum[0]   = 64'(sumA);
  assign actZc[0]    = 64'(zcA);
  assign actReady[1] = ifB.tready;
  assign actDone[1]  = doneB;
  assign actOvf[1]   = ovfB;
  assign actKe[1]    = keB;
  assign actCount[1] = 64'(countB);
  assign actMin[1]   = 64'(minB);
  assign actMax[1]   = 64'(maxB);
  assign actSum[1]   = 64'(sumB);
  assign actZc[1]    = 64'(zcB);

  int checks = 0;
  int errors = 0;

  function automatic int thrPer(int d);
    return (d == 0) ? 0 : 10;
  endfunction

  function automatic int thrLow(int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic int cntMax(int d);
    return (d == 0) ? 65535 : 15;
  endfunction

  function automatic string nm(int d, string s);
    return $sformatf("%s.%s", (d == 0) ? "A" : "B", s);
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model: samples of the open frame are kept verbatim; statistics are
  // derived from the whole list only when the frame closes.
  bit               mValid[2], mActive[2];
  int               mEnCnt[2], mN[2];
  logic signed [31:0] samp[2][4096];
  logic             expDone[2], expOvf[2], expKe[2];
  logic [63:0]      expCount[2], expMin[2], expMax[2], expSum[2], expZc[2];

  task automatic modelReset(int d);
    mValid[d]   = 1'b1;
    mActive[d]  = 1'b0;
    mEnCnt[d]   = 0;
    mN[d]       = 0;
    expDone[d]  = 1'b0;
    expOvf[d]   = 1'b0;
    expKe[d]    = 1'b0;
    expCount[d] = '0;
    expMin[d]   = '0;
    expMax[d]   = '0;
    expSum[d]   = '0;
    expZc[d]    = '0;
  endtask

  task automatic frameStats(int d);
    longint s;
    int z;
    int n;
    logic signed [31:0] mn, mx;
    n  = mN[d];
    s  = 0;
    z  = 0;
    mn = samp[d][0];
    mx = samp[d][0];
    for (int i = 0; i < n; i++) begin
      s += longint'(samp[d][i]);
      if (samp[d][i] < mn) mn = samp[d][i];
      if (samp[d][i] > mx) mx = samp[d][i];
      if (i > 0 && ((samp[d][i] < 0) != (samp[d][i-1] < 0))) z++;
    end
    expDone[d]  = 1'b1;
    expCount[d] = 64'((n > cntMax(d)) ? cntMax(d) : n);
    expOvf[d]   = (n > cntMax(d));
    expZc[d]    = 64'((z > cntMax(d)) ? cntMax(d) : z);
    expMin[d]   = {32'b0, mn};
    expMax[d]   = {32'b0, mx};
    expSum[d]   = {16'b0, s[47:0]};
  endtask

  always @(negedge clk) begin
    logic er, acc;
    for (int d = 0; d < 2; d++) begin
      er = 1'b0;
      if (mValid[d]) begin
        er = en[d] && mActive[d] &&
             !(thrPer(d) != 0 && (mEnCnt[d] % thrPer(d)) < thrLow(d));
        checkOutput(nm(d, "tready"),     64'(actReady[d]), 64'(er));
        checkOutput(nm(d, "frame_done"), 64'(actDone[d]),  64'(expDone[d]));
        checkOutput(nm(d, "keep_err"),   64'(actKe[d]),    64'(expKe[d]));
        checkOutput(nm(d, "stat_ovf"),   64'(actOvf[d]),   64'(expOvf[d]));
        checkOutput(nm(d, "stat_count"), actCount[d], expCount[d]);
        checkOutput(nm(d, "stat_min"),   actMin[d],   expMin[d]);
        checkOutput(nm(d, "stat_max"),   actMax[d],   expMax[d]);
        checkOutput(nm(d, "stat_sum"),   actSum[d],   expSum[d]);
        checkOutput(nm(d, "stat_zc"),    actZc[d],    expZc[d]);
      end
      if (rst[d]) begin
        modelReset(d);
      end else if (mValid[d]) begin
        acc        = tvalid[d] && er;
        expDone[d] = 1'b0;
        if (acc && tkeep[d] != 4'hF) expKe[d] = 1'b1;
        if (clr[d]) begin
          mN[d] = 0;
        end else if (acc) begin
          samp[d][mN[d]] = tdata[d];
          mN[d]++;
          if (tlast[d]) begin
            frameStats(d);
            mN[d] = 0;
          end
        end
        mActive[d] = en[d];
        if (en[d]) mEnCnt[d]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs(int d);
    en[d]     = 1'b0;
    clr[d]    = 1'b0;
    tvalid[d] = 1'b0;
    tlast[d]  = 1'b0;
    tkeep[d]  = 4'hF;
    tdata[d]  = '0;
  endtask

  task automatic resetDut(int d);
    rst[d] = 1'b1;
    idleInputs(d);
    repeat (3) tick();
    rst[d] = 1'b0;
  endtask

  // Presents one beat and holds it until accepted; reports cycles spent.
  task automatic applyStimulus(int d, logic [31:0] data, logic last, logic [3:0] keep,
                               output int waits);
    logic acc;
    tdata[d]  = data;
    tlast[d]  = last;
    tkeep[d]  = keep;
    tvalid[d] = 1'b1;
    waits     = 0;
    acc       = 1'b0;
    while (!acc && waits < 200) begin
      @(negedge clk);
      waits++;
      acc = actReady[d];
      tick();
    end
    if (!acc) checkOutput(nm(d, "beat_timeout"), 64'(0), 64'(1));
    tvalid[d] = 1'b0;
    tlast[d]  = 1'b0;
  endtask

  task automatic randomPhase(int d, int cycles);
    for (int c = 0; c < cycles; c++) begin
      rst[d]    = ($urandom_range(0, 399) == 0);
      en[d]     = ($urandom_range(0, 9) != 0);
      clr[d]    = ($urandom_range(0, 39) == 0);
      tvalid[d] = ($urandom_range(0, 3) != 0);
      tlast[d]  = ($urandom_range(0, 5) == 0);
      tkeep[d]  = ($urandom_range(0, 49) == 0) ? 4'h7 : 4'hF;
      case ($urandom_range(0, 2))
        0:       tdata[d] = $urandom;
        1:       tdata[d] = 32'($urandom_range(0, 20)) - 32'd10;
        default: tdata[d] = $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
      endcase
      tick();
    end
    rst[d] = 1'b0;
    idleInputs(d);
    repeat (3) tick();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w, span;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      idleInputs(d);
    end
    resetDut(0);
    resetDut(1);

    repeat (4) tick();
    checkOutput("A.idle_tready", 64'(actReady[0]), 64'(0));
    checkOutput("A.idle_count",  actCount[0], 64'(0));
    checkOutput("A.idle_sum",    actSum[0],   64'(0));

    en[0] = 1'b1;
    applyStimulus(0, 32'd100, 1'b0, 4'hF, w);
    applyStimulus(0, -32'sd50, 1'b0, 4'hF, w);
    applyStimulus(0, 32'd0, 1'b0, 4'hF, w);
    applyStimulus(0, 32'd7, 1'b1, 4'hF, w);
    checkOutput("A.f4_done",  64'(actDone[0]), 64'(1));
    checkOutput("A.f4_count", actCount[0], 64'd4);
    checkOutput("A.f4_min",   actMin[0],   64'h0000_0000_FFFF_FFCE);
    checkOutput("A.f4_max",   actMax[0],   64'd100);
    checkOutput("A.f4_sum",   actSum[0],   64'd57);
    checkOutput("A.f4_zc",    actZc[0],    64'd2);
    checkOutput("A.model_sum57", expSum[0], 64'd57);
    tick();
    checkOutput("A.f4_done_pulse", 64'(actDone[0]), 64'(0));

    applyStimulus(0, 32'h8000_0000, 1'b1, 4'hF, w);
    checkOutput("A.s1_count", actCount[0], 64'd1);
    checkOutput("A.s1_min",   actMin[0],   64'h8000_0000);
    checkOutput("A.s1_max",   actMax[0],   64'h8000_0000);
    checkOutput("A.s1_sum",   actSum[0],   64'h0000_FFFF_8000_0000);
    checkOutput("A.s1_zc",    actZc[0],    64'd0);

    applyStimulus(0, 32'd1, 1'b0, 4'hF, w);
    applyStimulus(0, 32'd2, 1'b0, 4'hF, w);
    applyStimulus(0, 32'd3, 1'b0, 4'hF, w);
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    checkOutput("A.clr_keep_count", actCount[0], 64'd1);
    applyStimulus(0, 32'd5, 1'b0, 4'hF, w);
    applyStimulus(0, 32'd5, 1'b1, 4'hF, w);
    checkOutput("A.clr_count", actCount[0], 64'd2);
    checkOutput("A.clr_sum",   actSum[0],   64'd10);
    checkOutput("A.model_count2", expCount[0], 64'd2);

    applyStimulus(0, 32'd9, 1'b1, 4'b0111, w);
    tick();
    checkOutput("A.keep_err_set", 64'(actKe[0]), 64'(1));
    applyStimulus(0, 32'd3, 1'b1, 4'hF, w);
    repeat (3) tick();
    checkOutput("A.keep_err_sticky", 64'(actKe[0]), 64'(1));
    idleInputs(0);
    tick();

    randomPhase(0, 1500);

    en[1] = 1'b1;
    span  = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 32'(i * 3) - 32'd20, (i == 19), 4'hF, w);
      span += w;
    end
    checkOutput("B.thr_span",  64'(span), 64'd29);
    checkOutput("B.sat_count", actCount[1], 64'd15);
    checkOutput("B.sat_ovf",   64'(actOvf[1]), 64'(1));
    checkOutput("B.model_ovf", 64'(expOvf[1]), 64'(1));
    idleInputs(1);
    tick();

    randomPhase(1, 1500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_fir_sink.md
Name: axis_fir_sink

Overview:
AXI-Stream slave that terminates the FIR output stream (m_axis_fir_*) in synthesizable form, replacing the behavioural capture logic in the bench. It accepts signed samples under a programmable back-pressure pattern and accumulates per-frame statistics: count, min, max, sum and sign-change count. On each tlast beat it latches the statistics to output registers. This lets the DEA flow collect FIR traces on-chip, not only in simulation.

Parameters:
DATA_W, 32, sample width (signed); multiple of 8
CNT_W, 16, width of sample and zero-crossing counters
SUM_W, 48, width of running sum accumulator
THR_PERIOD, 0, back-pressure period in cycles; 0 = tready never throttled
THR_LOW, 0, cycles per period with tready forced low; must be < THR_PERIOD

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = accept beats; 0 = tready low, statistics frozen
clear  in  1  1-cycle pulse: discard current partial frame
s_axis_tdata  in  DATA_W  signed sample
s_axis_tkeep  in  DATA_W/8  byte enables; must be all ones
s_axis_tvalid  in  1  beat valid
s_axis_tlast  in  1  last beat of frame
s_axis_tready  out  1  sink ready
frame_done  out  1  1-cycle pulse; statistics outputs updated
stat_count  out  CNT_W  samples in last completed frame
stat_min  out  DATA_W  signed minimum of last frame
stat_max  out  DATA_W  signed maximum of last frame
stat_sum  out  SUM_W  signed sum of last frame, sign-extended, wraps modulo 2^SUM_W
stat_zc  out  CNT_W  sign changes between consecutive samples of last frame
stat_ovf  out  1  last frame's sample count saturated
keep_err  out  1  sticky: a beat with tkeep != all ones was accepted

Behaviour:
- Beat accepted when s_axis_tvalid && s_axis_tready on a rising clk edge. tdata/tlast/tkeep are sampled only on accepted beats.
- Reset: tready=0; frame_done=0; all stat_* = 0; stat_ovf=0; keep_err=0; throttle counter=0; FSM to IDLE.
- FSM states and transitions:
  - IDLE: tready=0. Go to FIRST when enable=1.
  - FIRST: awaiting first beat of a frame.
    - On accept: min=max=sum=sample, count=1, zc=0, store sign of sample as prev_sign.
    - If that beat also has tlast: single-sample frame; latch and pulse, stay in FIRST.
    - Otherwise go to ACCUM.
  - ACCUM, on each accepted beat:
    - count += 1, saturating at 2^CNT_W-1; ovf set on saturation.
    - min/max updated by signed compare.
    - sum += sign-extended sample.
    - zc += 1 when sign(sample) != prev_sign; sign = MSB, so zero counts as non-negative. zc saturates.
    - On tlast: latch results and go to FIRST.
  - enable=0 in FIRST or ACCUM: go to IDLE, keeping partial accumulators. Re-enabling resumes in the state that was left.
- Latch: stat_* registered from the values that include the tlast beat. frame_done=1 in the cycle after the accepting edge. Latency tlast beat -> frame_done = 1 cycle.
- tready = enable && (state != IDLE) && !throttle_low.
  - throttle_low = (THR_PERIOD != 0) && (thr_cnt < THR_LOW).
  - thr_cnt counts 0..THR_PERIOD-1 and wraps; it free-runs while enable=1 and holds while enable=0.
- tready is independent of tvalid (no combinational tvalid->tready path).
- clear=1: accumulators reset, FSM to FIRST (or IDLE if enable=0). No frame_done, stat_* unchanged. A beat accepted in the same cycle is discarded.
- keep_err is cleared only by reset.
- reset mid-frame: partial frame discarded, no frame_done.

Decomposition:
- Package axis_fir_pkg:
  - state enum {IDLE, FIRST, ACCUM}
  - SAT helper constants (CNT_MAX)
  - default widths shared with FIR (FIR_OUT_W=32, FIR_IN_W=16)
- Sub-module axis_throttle: thr_cnt plus throttle_low generation, parameters THR_PERIOD/THR_LOW. Reusable by a future stream source.

Test Plan:
- Reset and idle: reset=1 for 3 cycles, then enable=0 -> tready=0, all stat_*=0, frame_done never asserted.
- 4-beat frame, no throttle: samples 100, -50, 0, 7 (tlast on 7) -> stat_count=4, min=-50, max=100, sum=57, zc=2, frame_done one cycle after the 7 beat.
- Throttle: THR_PERIOD=10, THR_LOW=3, tvalid held 1 -> tready low exactly 3 of every 10 cycles; 20-beat frame completes in 29 cycles.
- Single-beat frame: sample 32'h8000_0000 with tlast -> count=1, min=max=-2^31, sum=sign-extended -2^31, zc=0.
- clear mid-frame: 3 beats, clear, then 2 beats of 5, 5 with tlast -> count=2, sum=10, previous stat values unchanged until this frame_done.
- keep_err and saturation: one beat with tkeep=4'b0111 -> keep_err=1 and sticky. With CNT_W=4, a 20-beat frame -> count=15, stat_ovf=1.
